// File: rtl/washer_pkg.sv
// Shared opcode, field-offset and state definitions for the washer sequencer core.
package washer_pkg;

  localparam int IMM_LSB = 16;
  localparam int SEL_LSB = 8;
  localparam int OP_LSB  = 0;

  localparam logic [7:0] OP_WAIT    = 8'h01;
  localparam logic [7:0] OP_FILL    = 8'h02;
  localparam logic [7:0] OP_RELEASE = 8'h03;
  localparam logic [7:0] OP_FWD     = 8'h04;
  localparam logic [7:0] OP_REV     = 8'h05;
  localparam logic [7:0] OP_ACT     = 8'h06;
  localparam logic [7:0] OP_SET     = 8'h11;
  localparam logic [7:0] OP_DEC     = 8'h12;
  localparam logic [7:0] OP_JZ      = 8'h21;
  localparam logic [7:0] OP_JMP     = 8'h22;
  localparam logic [7:0] OP_JNZ     = 8'h23;
  localparam logic [7:0] OP_HALT    = 8'h30;

  typedef enum logic [1:0] {S_FETCH, S_RUN, S_HALT} state_t;

endpackage

// File: rtl/washer_timer.sv
// Duration timer: TICK_DIV prescaler feeding an IMM_W down-counter.
// o_done flags the enabled cycle whose clock edge takes the count from 1 to 0.
module washer_timer #(
  parameter int IMM_W    = 16,
  parameter int TICK_DIV = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ena,
  input  logic             i_load,
  input  logic [IMM_W-1:0] i_load_val,
  output logic [IMM_W-1:0] o_count,
  output logic             o_done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  logic [PW-1:0]    r_presc;
  logic [IMM_W-1:0] r_count;
  logic             w_tick;

  assign w_tick  = i_ena && (r_count != '0) && (r_presc == PMAX);
  assign o_done  = w_tick && (r_count == IMM_W'(1));
  assign o_count = r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_presc <= '0;
      r_count <= '0;
    end else if (i_ena) begin
      if (i_load) begin
        r_count <= i_load_val;
        r_presc <= '0;
      end else if (r_count != '0) begin
        if (r_presc == PMAX) begin
          r_presc <= '0;
          r_count <= r_count - 1'b1;
        end else begin
          r_presc <= r_presc + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/washer_seq_core.sv
// Washing-machine sequencer: fetch/execute FSM, pc, loop registers and one-hot
// actuator register, driving timed channel pulses from a 32-bit program ROM.
module washer_seq_core
  import washer_pkg::*;
#(
  parameter int PC_W     = 8,
  parameter int IMM_W    = 16,
  parameter int NUM_CH   = 4,
  parameter int NUM_REG  = 4,
  parameter int TICK_DIV = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ena,
  input  logic [31:0]       i_instr,
  output logic [PC_W-1:0]   o_pc,
  output logic [NUM_CH-1:0] o_ctrl,
  output logic              o_busy,
  output logic [IMM_W-1:0]  o_time_left,
  output logic              o_halted,
  output logic              o_illegal
);

  localparam int RW = (NUM_REG > 1) ? $clog2(NUM_REG) : 1;
  localparam logic [7:0] NCH8  = 8'(NUM_CH);
  localparam logic [7:0] NREG8 = 8'(NUM_REG);

  state_t                          r_state;
  logic [PC_W-1:0]                 r_pc;
  logic [NUM_CH-1:0]               r_ctrl;
  logic                            r_busy, r_halted, r_illegal;
  logic [NUM_REG-1:0][IMM_W-1:0]   r_regs;

  logic [7:0]        w_op, w_sel;
  logic [IMM_W-1:0]  w_imm, w_rval, w_count;
  logic [RW-1:0]     w_ridx;
  logic [PC_W-1:0]   w_pc_inc, w_target;
  logic [3:0]        w_ch;
  logic [NUM_CH-1:0] w_onehot;
  logic              w_reg_ok, w_timed, w_has_ch, w_ch_ok, w_trap, w_load, w_done;

  assign w_op     = i_instr[OP_LSB +: 8];
  assign w_sel    = i_instr[SEL_LSB +: 8];
  assign w_imm    = i_instr[IMM_LSB +: IMM_W];
  assign w_ridx   = w_sel[RW-1:0];
  assign w_reg_ok = (w_sel < NREG8);
  assign w_rval   = r_regs[w_ridx];
  assign w_pc_inc = r_pc + 1'b1;
  assign w_target = w_imm[PC_W-1:0];
  assign w_onehot = w_has_ch ? (NUM_CH'(1) << w_ch) : '0;

  always_comb begin
    w_timed  = 1'b0;
    w_has_ch = 1'b0;
    w_ch     = '0;
    w_ch_ok  = 1'b1;
    w_trap   = 1'b0;
    case (w_op)
      OP_WAIT: w_timed = 1'b1;
      OP_FILL, OP_RELEASE, OP_FWD, OP_REV: begin
        w_timed  = 1'b1;
        w_has_ch = 1'b1;
        w_ch     = w_op[3:0] - 4'd2;
        w_ch_ok  = ({4'b0, w_ch} < NCH8);
        w_trap   = !w_ch_ok;
      end
      OP_ACT: begin
        w_timed  = 1'b1;
        w_has_ch = 1'b1;
        w_ch     = w_sel[3:0];
        w_ch_ok  = (w_sel < NCH8);
        w_trap   = !w_ch_ok;
      end
      OP_SET, OP_DEC, OP_JZ, OP_JNZ: w_trap = !w_reg_ok;
      OP_JMP, OP_HALT: w_trap = 1'b0;
      default: w_trap = 1'b1;
    endcase
  end

  assign w_load = (r_state == S_FETCH) && i_ena && w_timed && !w_trap && (w_imm != '0);

  washer_timer #(.IMM_W(IMM_W), .TICK_DIV(TICK_DIV)) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_ena      (i_ena),
    .i_load     (w_load),
    .i_load_val (w_imm),
    .o_count    (w_count),
    .o_done     (w_done)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_FETCH;
      r_pc      <= '0;
      r_ctrl    <= '0;
      r_busy    <= 1'b0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
      r_regs    <= '0;
    end else if (i_ena) begin
      case (r_state)
        S_FETCH: begin
          if (w_trap) begin
            r_illegal <= 1'b1;
            r_halted  <= 1'b1;
            r_state   <= S_HALT;
          end else if (w_timed) begin
            if (w_imm == '0) begin
              r_pc <= w_pc_inc;
            end else begin
              r_ctrl  <= w_onehot;
              r_busy  <= 1'b1;
              r_state <= S_RUN;
            end
          end else begin
            case (w_op)
              OP_SET: begin
                r_regs[w_ridx] <= w_imm;
                r_pc           <= w_pc_inc;
              end
              OP_DEC: begin
                if (w_rval != '0) r_regs[w_ridx] <= w_rval - 1'b1;
                r_pc <= w_pc_inc;
              end
              OP_JZ:  r_pc <= (w_rval == '0) ? w_target : w_pc_inc;
              OP_JNZ: r_pc <= (w_rval != '0) ? w_target : w_pc_inc;
              OP_JMP: r_pc <= w_target;
              default: begin
                r_halted <= 1'b1;
                r_state  <= S_HALT;
              end
            endcase
          end
        end
        S_RUN: begin
          if (w_done) begin
            r_ctrl  <= '0;
            r_busy  <= 1'b0;
            r_pc    <= w_pc_inc;
            r_state <= S_FETCH;
          end
        end
        S_HALT: ;
        default: r_state <= S_HALT;
      endcase
    end
  end

  // Actuators drop the moment ena falls and come back as soon as it rises;
  // the held r_ctrl remembers which channel to restore.
  assign o_ctrl      = r_ctrl & {NUM_CH{i_ena}};
  assign o_pc        = r_pc;
  assign o_busy      = r_busy;
  assign o_time_left = w_count;
  assign o_halted    = r_halted;
  assign o_illegal   = r_illegal;

endmodule

// File: tb/tb_washer_seq_core.sv
// Directed bench: single-instruction vector table plus hand-written multi-cycle sequences.
module tb_washer_seq_core;

  logic clk = 1'b0;
  logic rst, ena;
  always #5 clk = ~clk;

  logic [31:0] rom_a [256];
  logic [31:0] rom_b [256];
  logic [31:0] instr_a, instr_b;
  logic [7:0]  pc_a, pc_b;
  logic [3:0]  ctrl_a, ctrl_b;
  logic        busy_a, busy_b, halt_a, halt_b, ill_a, ill_b;
  logic [15:0] tl_a, tl_b;

  assign instr_a = rom_a[pc_a];
  assign instr_b = rom_b[pc_b];

  washer_seq_core #(.PC_W(8), .IMM_W(16), .NUM_CH(4), .NUM_REG(4), .TICK_DIV(1)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_instr(instr_a),
    .o_pc(pc_a), .o_ctrl(ctrl_a), .o_busy(busy_a), .o_time_left(tl_a),
    .o_halted(halt_a), .o_illegal(ill_a)
  );

  washer_seq_core #(.PC_W(8), .IMM_W(16), .NUM_CH(4), .NUM_REG(4), .TICK_DIV(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_instr(instr_b),
    .o_pc(pc_b), .o_ctrl(ctrl_b), .o_busy(busy_b), .o_time_left(tl_b),
    .o_halted(halt_b), .o_illegal(ill_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fill_halt();
    for (int i = 0; i < 256; i++) begin
      rom_a[i] = 32'h0000_0030;
      rom_b[i] = 32'h0000_0030;
    end
  endtask

  // Reset held 3 cycles, released at a falling edge.
  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    string       name;
    logic [31:0] instr;
    int          k;
    logic [7:0]  pc;
    logic [3:0]  ctrl;
    logic        busy;
    logic [15:0] tl;
    logic        halted;
    logic        illegal;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int hi, bad;
    rst = 1'b1;
    ena = 1'b1;
    fill_halt();

    vecs[0]  = '{"fill_k1",     32'h0020_0002,  1, 8'h00, 4'b0001, 1'b1, 16'd32, 1'b0, 1'b0};
    vecs[1]  = '{"fill_k32",    32'h0020_0002, 32, 8'h00, 4'b0001, 1'b1, 16'd1,  1'b0, 1'b0};
    vecs[2]  = '{"fill_k33",    32'h0020_0002, 33, 8'h01, 4'b0000, 1'b0, 16'd0,  1'b0, 1'b0};
    vecs[3]  = '{"fill_then_h", 32'h0020_0002, 34, 8'h01, 4'b0000, 1'b0, 16'd0,  1'b1, 1'b0};
    vecs[4]  = '{"act_sel2",    32'h0003_0206,  1, 8'h00, 4'b0100, 1'b1, 16'd3,  1'b0, 1'b0};
    vecs[5]  = '{"act_sel9",    32'h0005_0906,  1, 8'h00, 4'b0000, 1'b0, 16'd0,  1'b1, 1'b1};
    vecs[6]  = '{"op_7f",       32'h0000_007F,  1, 8'h00, 4'b0000, 1'b0, 16'd0,  1'b1, 1'b1};
    vecs[7]  = '{"wait0",       32'h0000_0001,  1, 8'h01, 4'b0000, 1'b0, 16'd0,  1'b0, 1'b0};
    vecs[8]  = '{"jmp55",       32'h0055_0022,  1, 8'h55, 4'b0000, 1'b0, 16'd0,  1'b0, 1'b0};
    vecs[9]  = '{"jz_taken",    32'h0010_0021,  1, 8'h10, 4'b0000, 1'b0, 16'd0,  1'b0, 1'b0};
    vecs[10] = '{"jnz_fall",    32'h0010_0023,  1, 8'h01, 4'b0000, 1'b0, 16'd0,  1'b0, 1'b0};
    vecs[11] = '{"set_r9",      32'h0001_0911,  1, 8'h00, 4'b0000, 1'b0, 16'd0,  1'b1, 1'b1};
    vecs[12] = '{"halt",        32'h0000_0030,  5, 8'h00, 4'b0000, 1'b0, 16'd0,  1'b1, 1'b0};
    vecs[13] = '{"wait5_k3",    32'h0005_0001,  3, 8'h00, 4'b0000, 1'b1, 16'd3,  1'b0, 1'b0};
    vecs[14] = '{"rev_leg",     32'h0002_0005,  1, 8'h00, 4'b1000, 1'b1, 16'd2,  1'b0, 1'b0};
    vecs[15] = '{"dec_r0_zero", 32'h0000_0012,  1, 8'h01, 4'b0000, 1'b0, 16'd0,  1'b0, 1'b0};

    // Reset state
    do_reset();
    #1;
    chk("rst_pc", pc_a, 0);
    chk("rst_ctrl", ctrl_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_halted", halt_a, 0);
    chk("rst_illegal", ill_a, 0);

    foreach (vecs[v]) begin
      fill_halt();
      rom_a[0] = vecs[v].instr;
      do_reset();
      step(vecs[v].k);
      chk({vecs[v].name, "_pc"},      pc_a,   vecs[v].pc);
      chk({vecs[v].name, "_ctrl"},    ctrl_a, vecs[v].ctrl);
      chk({vecs[v].name, "_busy"},    busy_a, vecs[v].busy);
      chk({vecs[v].name, "_tl"},      tl_a,   vecs[v].tl);
      chk({vecs[v].name, "_halted"},  halt_a, vecs[v].halted);
      chk({vecs[v].name, "_illegal"}, ill_a,  vecs[v].illegal);
    end

    // FILL 32: ctrl high for exactly 32 cycles, busy tracks it
    fill_halt();
    rom_a[0] = 32'h0020_0002;
    do_reset();
    hi = 0; bad = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (ctrl_a == 4'b0001) hi++;
      if (busy_a != (ctrl_a != 4'b0000)) bad++;
    end
    chk("fill32_high_cycles", hi, 32);
    chk("fill32_busy_track", bad, 0);

    // TICK_DIV=4, ACT sel=3 imm=5
    fill_halt();
    rom_b[0] = 32'h0005_0306;
    do_reset();
    hi = 0;
    for (int k = 1; k <= 24; k++) begin
      step(1);
      if (ctrl_b == 4'b1000) hi++;
      if ((k % 4) == 1 && k <= 21) chk($sformatf("div4_tl_k%0d", k), tl_b, 5 - (k - 1) / 4);
    end
    chk("div4_high_cycles", hi, 20);
    chk("div4_pc", pc_b, 1);
    chk("div4_busy_end", busy_b, 0);

    // Counted loop: SET r1=2; WAIT 3; DEC r1; JNZ r1->1; DEC r1; JZ r1->0x20
    fill_halt();
    rom_a[0] = 32'h0002_0111;
    rom_a[1] = 32'h0003_0001;
    rom_a[2] = 32'h0000_0112;
    rom_a[3] = 32'h0001_0123;
    rom_a[4] = 32'h0000_0112;
    rom_a[5] = 32'h0020_0121;
    do_reset();
    hi = 0;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      if (busy_a) hi++;
      if (k == 13) chk("loop_exit_pc", pc_a, 4);
    end
    chk("loop_busy_cycles", hi, 6);
    chk("loop_final_pc", pc_a, 8'h20);
    chk("loop_halted", halt_a, 1);
    chk("loop_no_illegal", ill_a, 0);

    // Pause mid-FILL at time_left=7
    fill_halt();
    rom_a[0] = 32'h000A_0002;
    do_reset();
    hi = 0;
    for (int k = 0; k < 4; k++) begin
      step(1);
      if (ctrl_a == 4'b0001) hi++;
    end
    chk("pause_tl_before", tl_a, 7);
    ena = 1'b0;
    #1;
    chk("pause_ctrl_drop", ctrl_a, 0);
    step(10);
    chk("pause_tl_held", tl_a, 7);
    chk("pause_ctrl_off", ctrl_a, 0);
    chk("pause_pc_held", pc_a, 0);
    ena = 1'b1;
    #1;
    chk("pause_ctrl_restore", ctrl_a, 4'b0001);
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (ctrl_a == 4'b0001) hi++;
      if (pc_a == 8'h01) break;
    end
    chk("pause_total_high", hi, 10);
    chk("pause_done_pc", pc_a, 1);

    // Illegal opcode holds for 20 cycles, reset clears it
    fill_halt();
    rom_a[0] = 32'h0000_007F;
    do_reset();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (pc_a != 8'h00 || ctrl_a != 4'b0000 || !halt_a || !ill_a) bad++;
    end
    chk("illegal_hold", bad, 0);
    do_reset();
    #1;
    chk("illegal_cleared", ill_a, 0);
    chk("halted_cleared", halt_a, 0);

    // pc wrap via JMP 0xFF, then async reset mid-RUN
    fill_halt();
    rom_a[0]   = 32'h00FF_0022;
    rom_a[255] = 32'h0000_0001;
    do_reset();
    step(1);
    chk("wrap_jmp_pc", pc_a, 8'hFF);
    step(1);
    chk("wrap_pc0", pc_a, 8'h00);
    rom_a[0] = 32'h0014_0002;
    step(5);
    chk("midrun_ctrl_on", ctrl_a, 4'b0001);
    rst = 1'b1;
    #1;
    chk("midrun_rst_ctrl", ctrl_a, 0);
    chk("midrun_rst_pc", pc_a, 0);
    chk("midrun_rst_busy", busy_a, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
